// File: rtl/logic_gate_tester_if.sv
// Bus between the self-test sequencer and the two-input logic-gate block.
// The master drives the gate inputs and reads back the eight gate outputs.
interface logic_gate_tester_if;
    logic gate_a;
    logic gate_b;
    logic and_in;
    logic or_in;
    logic not_a_in;
    logic not_b_in;
    logic nand_in;
    logic nor_in;
    logic xor_in;
    logic xnor_in;

    modport master (
        output gate_a, gate_b,
        input  and_in, or_in, not_a_in, not_b_in, nand_in, nor_in, xor_in, xnor_in
    );

    modport slave (
        input  gate_a, gate_b,
        output and_in, or_in, not_a_in, not_b_in, nand_in, nor_in, xor_in, xnor_in
    );
endinterface

// File: rtl/logic_gate_tester.sv
// Self-test sequencer: walks the gate block through all four a/b vectors,
// compares each settled sample with a golden truth table and publishes the result.
module logic_gate_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     loop_en,
    logic_gate_tester_if.master      gates,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [7:0]               err_mask,
    output logic [3:0]               fail_vec,
    output logic [CNT_W-1:0]         run_count
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [1:0]  v;
    logic [7:0]  settle_cnt;
    logic [7:0]  err_acc;
    logic [3:0]  fail_acc;
    logic [7:0]  sample_word;
    logic [7:0]  diff;
    logic        start_run;
    logic        advance;
    logic        publish;

    function automatic logic [7:0] golden_word(input logic [1:0] idx);
        case (idx)
            2'd0:    golden_word = 8'hBC;
            2'd1:    golden_word = 8'h56;
            2'd2:    golden_word = 8'h5A;
            default: golden_word = 8'h83;
        endcase
    endfunction

    assign gates.gate_a = v[1];
    assign gates.gate_b = v[0];

    assign sample_word = {gates.xnor_in, gates.xor_in, gates.nor_in, gates.nand_in,
                          gates.not_b_in, gates.not_a_in, gates.or_in, gates.and_in};
    assign diff = sample_word ^ golden_word(v);

    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        advance    = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WAIT;
                    start_run  = 1'b1;
                end
            end
            WAIT: begin
                if (settle_cnt == 8'd0) next_state = SAMPLE;
            end
            SAMPLE: begin
                if (v == 2'd3) begin
                    next_state = DONE;
                end else begin
                    next_state = WAIT;
                    advance    = 1'b1;
                end
            end
            DONE: begin
                publish = 1'b1;
                // A looped restart behaves exactly like an accepted start.
                if (loop_en) begin
                    next_state = WAIT;
                    start_run  = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v          <= 2'd0;
            settle_cnt <= 8'd0;
            err_acc    <= 8'd0;
            fail_acc   <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_mask   <= 8'd0;
            fail_vec   <= 4'd0;
            run_count  <= '0;
        end else begin
            state <= next_state;
            done  <= publish;

            if (start_run) begin
                v          <= 2'd0;
                settle_cnt <= SETTLE_LOAD;
                err_acc    <= 8'd0;
                fail_acc   <= 4'd0;
                busy       <= 1'b1;
            end else if (state == WAIT && settle_cnt != 8'd0) begin
                settle_cnt <= settle_cnt - 8'd1;
            end

            if (state == SAMPLE) begin
                err_acc     <= err_acc | diff;
                fail_acc[v] <= (diff != 8'd0);
                if (advance) begin
                    v          <= v + 2'd1;
                    settle_cnt <= SETTLE_LOAD;
                end
            end

            // Results only move here, so a partial run is never visible.
            if (publish) begin
                err_mask <= err_acc;
                fail_vec <= fail_acc;
                pass     <= (err_acc == 8'd0);
                if (run_count != {CNT_W{1'b1}}) run_count <= run_count + CNT_W'(1);
                if (!loop_en) busy <= 1'b0;
            end
        end
    end

endmodule
